// File: rtl/ov5640_pkg.sv
// Shared definitions for the OV5640 configuration sequencer: FSM encoding,
// SCCB device addresses and the field layout of the 32-bit IIC command word.
package ov5640_pkg;

   typedef enum logic [3:0] {
      StIdle,
      StSettle,
      StLoad,
      StFire,
      StWaitH,
      StWaitL,
      StNext,
      StReady,
      StExtFire,
      StExtWaitH,
      StExtWaitL,
      StErr
   } state_t;

   localparam logic [7:0] DEV_WR = 8'h78;
   localparam logic [7:0] DEV_RD = 8'h79;

   // Command word layout: {device, register address, data}
   localparam int unsigned DEV_MSB = 31;
   localparam int unsigned DEV_LSB = 24;
   localparam int unsigned REG_MSB = 23;
   localparam int unsigned REG_LSB = 8;
   localparam int unsigned DAT_MSB = 7;
   localparam int unsigned DAT_LSB = 0;

   function automatic logic [31:0] pack_wdata(input logic [7:0]  dev,
                                              input logic [23:0] reg_data);
      logic [31:0] w;
      w                  = '0;
      w[DEV_MSB:DEV_LSB] = dev;
      w[REG_MSB:REG_LSB] = reg_data[23:8];
      w[DAT_MSB:DAT_LSB] = reg_data[7:0];
      return w;
   endfunction

endpackage

// File: rtl/ov5640_cfg_rom.sv
// Sensor register table: maps a table index to {reg_addr[15:0], reg_val[7:0]}.
// Indices past REG_NUM read as zero; indices inside REG_NUM that have no
// explicit entry repeat the idempotent "sensor awake" write.
module ov5640_cfg_rom #(
   parameter int unsigned REG_NUM = 250
) (
   input  logic [7:0]  idx,
   output logic [23:0] rom_data
);

   // Combinational register table lookup
   always_comb begin
      rom_data = {16'h3008, 8'h02};
      case (idx)
         8'd0:    rom_data = {16'h3008, 8'h82}; // software reset
         8'd1:    rom_data = {16'h3008, 8'h02}; // leave power-down
         8'd2:    rom_data = {16'h3103, 8'h02}; // system clock from PLL
         8'd3:    rom_data = {16'h3017, 8'hff}; // pad output enables
         8'd4:    rom_data = {16'h3018, 8'hff};
         8'd5:    rom_data = {16'h3034, 8'h1a}; // MIPI 10-bit mode
         8'd6:    rom_data = {16'h3037, 8'h13}; // PLL root divider
         8'd7:    rom_data = {16'h3108, 8'h01}; // PCLK root divider
         8'd8:    rom_data = {16'h3630, 8'h36};
         8'd9:    rom_data = {16'h3631, 8'h0e};
         8'd10:   rom_data = {16'h3632, 8'he2};
         8'd11:   rom_data = {16'h3633, 8'h12};
         8'd12:   rom_data = {16'h3621, 8'he0};
         8'd13:   rom_data = {16'h3704, 8'ha0};
         8'd14:   rom_data = {16'h3703, 8'h5a};
         8'd15:   rom_data = {16'h3715, 8'h78};
         8'd16:   rom_data = {16'h3717, 8'h01};
         8'd17:   rom_data = {16'h370b, 8'h60};
         8'd18:   rom_data = {16'h3705, 8'h1a};
         8'd19:   rom_data = {16'h3905, 8'h02};
         default: rom_data = {16'h3008, 8'h02};
      endcase
      if (32'(idx) >= REG_NUM) begin
         rom_data = '0;
      end
   end

endmodule

// File: rtl/ov5640_cfg_ctrl.sv
// OV5640 configuration sequencer: after power-up settle, writes the register
// table through the ov5640_iic start/busy handshake, then serves one external
// requester for runtime register accesses.
module ov5640_cfg_ctrl #(
   parameter int unsigned REG_NUM      = 250,
   parameter int unsigned SETTLE_CNT   = 1_000_000,
   parameter int unsigned BUSY_TIMEOUT = 65_535,
   parameter logic [7:0]  DEV_WR       = ov5640_pkg::DEV_WR
) (
   input  logic        sclk,
   input  logic        s_rst_n,
   input  logic        power_done,
   input  logic        busy,
   input  logic [7:0]  riic_data,
   output logic        start,
   output logic [31:0] wdata,
   output logic        cfg_done,
   output logic        cfg_err,
   input  logic        ext_req,
   input  logic [31:0] ext_wdata,
   output logic        ext_ack,
   output logic [7:0]  ext_rdata
);

   import ov5640_pkg::*;

   localparam int unsigned SettleW = (SETTLE_CNT > 1) ? $clog2(SETTLE_CNT) : 1;
   localparam int unsigned ToW     = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

   state_t             r_state;
   state_t             w_state_d;
   logic [SettleW-1:0] r_settle_cnt;
   logic [ToW-1:0]     r_to_cnt;
   logic [7:0]         r_idx;
   logic [31:0]        r_wdata;
   logic               r_cfg_done;
   logic               r_ext_ack;
   logic [7:0]         r_ext_rdata;
   logic [23:0]        w_rom_data;
   logic               w_last;
   logic               w_settle_last;
   logic               w_to_last;

   ov5640_cfg_rom #(
      .REG_NUM (REG_NUM)
   ) u_rom (
      .idx      (r_idx),
      .rom_data (w_rom_data)
   );

   assign w_last        = (r_idx == 8'(REG_NUM - 1));
   assign w_settle_last = (r_settle_cnt == SettleW'(SETTLE_CNT - 1));
   assign w_to_last     = (r_to_cnt == ToW'(BUSY_TIMEOUT - 1));

   // State register
   always_ff @(posedge sclk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_d;
      end
   end

   // Next-state logic; power loss aborts only the table phase, ERR is terminal
   always_comb begin
      w_state_d = r_state;
      unique case (r_state)
         StIdle:     if (power_done) w_state_d = StSettle;
         StSettle:   if (!power_done) w_state_d = StIdle;
                     else if (w_settle_last) w_state_d = StLoad;
         // Hold off the next start while a previous (aborted) transfer drains
         StLoad:     if (!power_done) w_state_d = StIdle;
                     else if (!busy) w_state_d = StFire;
         StFire:     if (!power_done) w_state_d = StIdle;
                     else w_state_d = StWaitH;
         StWaitH:    if (!power_done) w_state_d = StIdle;
                     else if (busy) w_state_d = StWaitL;
                     else if (w_to_last) w_state_d = StErr;
         StWaitL:    if (!power_done) w_state_d = StIdle;
                     else if (!busy) w_state_d = StNext;
                     else if (w_to_last) w_state_d = StErr;
         StNext:     if (!power_done) w_state_d = StIdle;
                     else if (w_last) w_state_d = StReady;
                     else w_state_d = StLoad;
         // Requester still sees its own ack this cycle; don't re-accept it
         StReady:    if (ext_req && !r_ext_ack) w_state_d = StExtFire;
         StExtFire:  w_state_d = StExtWaitH;
         StExtWaitH: if (busy) w_state_d = StExtWaitL;
                     else if (w_to_last) w_state_d = StErr;
         StExtWaitL: if (!busy) w_state_d = StReady;
                     else if (w_to_last) w_state_d = StErr;
         StErr:      w_state_d = StErr;
         default:    w_state_d = StIdle;
      endcase
   end

   // Moore outputs; cfg_done also rises during the final NEXT cycle
   always_comb begin
      start    = (r_state == StFire) || (r_state == StExtFire);
      cfg_err  = (r_state == StErr);
      cfg_done = r_cfg_done || ((r_state == StNext) && w_last && power_done);
   end

   // Settle and busy-timeout counters
   always_ff @(posedge sclk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         r_settle_cnt <= '0;
         r_to_cnt     <= '0;
      end else begin
         if (r_state == StIdle) begin
            r_settle_cnt <= '0;
         end else if (r_state == StSettle) begin
            r_settle_cnt <= r_settle_cnt + SettleW'(1);
         end
         if ((r_state == StFire) || (r_state == StExtFire)) begin
            r_to_cnt <= '0;
         end else if ((r_state == StWaitH) || (r_state == StWaitL) ||
                      (r_state == StExtWaitH) || (r_state == StExtWaitL)) begin
            r_to_cnt <= r_to_cnt + ToW'(1);
         end
      end
   end

   // Table index, command word and sticky done flag
   always_ff @(posedge sclk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         r_idx      <= '0;
         r_wdata    <= '0;
         r_cfg_done <= 1'b0;
      end else begin
         if (w_state_d == StIdle) begin
            r_idx <= '0;
         end else if ((r_state == StNext) && (w_state_d == StLoad)) begin
            r_idx <= r_idx + 8'd1;
         end
         if (r_state == StLoad) begin
            r_wdata <= pack_wdata(DEV_WR, w_rom_data);
         end else if ((r_state == StReady) && (w_state_d == StExtFire)) begin
            r_wdata <= ext_wdata;
         end
         if ((r_state == StNext) && (w_state_d == StReady)) begin
            r_cfg_done <= 1'b1;
         end
      end
   end

   // External completion pulse and read-data capture
   always_ff @(posedge sclk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         r_ext_ack   <= 1'b0;
         r_ext_rdata <= '0;
      end else begin
         r_ext_ack <= (r_state == StExtWaitL) && (w_state_d == StReady);
         if ((r_state == StExtWaitL) && (w_state_d == StReady)) begin
            r_ext_rdata <= riic_data;
         end
      end
   end

   assign wdata     = r_wdata;
   assign ext_ack   = r_ext_ack;
   assign ext_rdata = r_ext_rdata;

endmodule

// File: tb/tb_ov5640_cfg_ctrl.sv
// Bench for ov5640_cfg_ctrl: boot table walk, external transfers, async reset
// mid-transfer, power loss replay and busy timeout.
module tb_ov5640_cfg_ctrl;

   localparam int unsigned RegNum      = 3;
   localparam int unsigned SettleCnt   = 10;
   localparam int unsigned BusyTimeout = 20;

   logic        sclk       = 1'b0;
   logic        s_rst_n    = 1'b0;
   logic        power_done = 1'b0;
   logic        busy       = 1'b0;
   logic [7:0]  riic_data  = 8'h00;
   logic        ext_req    = 1'b0;
   logic [31:0] ext_wdata  = 32'h0;
   logic        start;
   logic [31:0] wdata;
   logic        cfg_done;
   logic        cfg_err;
   logic        ext_ack;
   logic [7:0]  ext_rdata;

   ov5640_cfg_ctrl #(
      .REG_NUM      (RegNum),
      .SETTLE_CNT   (SettleCnt),
      .BUSY_TIMEOUT (BusyTimeout),
      .DEV_WR       (8'h78)
   ) dut (
      .sclk       (sclk),
      .s_rst_n    (s_rst_n),
      .power_done (power_done),
      .busy       (busy),
      .riic_data  (riic_data),
      .start      (start),
      .wdata      (wdata),
      .cfg_done   (cfg_done),
      .cfg_err    (cfg_err),
      .ext_req    (ext_req),
      .ext_wdata  (ext_wdata),
      .ext_ack    (ext_ack),
      .ext_rdata  (ext_rdata)
   );

   always #5 sclk = ~sclk;

   // IIC master model: busy high for 5 cycles starting at the edge that sees start
   logic busy_en = 1'b1;
   int   bcnt    = 0;
   always @(posedge sclk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         busy <= 1'b0;
         bcnt <= 0;
      end else if (start && busy_en) begin
         busy <= 1'b1;
         bcnt <= 5;
      end else if (bcnt > 1) begin
         bcnt <= bcnt - 1;
      end else begin
         busy <= 1'b0;
         bcnt <= 0;
      end
   end

   int cyc = 0;
   always @(posedge sclk) cyc <= cyc + 1;

   // Monitor sampled on the falling edge
   int          n_start, n_ack, n_viol, n_wide;
   int          fall_cyc, done_cyc, start_cyc, err_cyc;
   logic        prev_start, prev_busy, prev_done, prev_err;
   logic [31:0] wlog[$];
   always @(negedge sclk) begin
      if (start) begin
         n_start++;
         wlog.push_back(wdata);
         start_cyc = cyc;
         if (busy) n_viol++;
         if (prev_start) n_wide++;
      end
      if (ext_ack) n_ack++;
      if (prev_busy && !busy) fall_cyc = cyc;
      if (cfg_done && !prev_done) done_cyc = cyc;
      if (cfg_err && !prev_err) err_cyc = cyc;
      prev_start = start;
      prev_busy  = busy;
      prev_done  = cfg_done;
      prev_err   = cfg_err;
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge sclk);
      #1;
   endtask

   task automatic clear_mon();
      n_start  = 0;
      n_ack    = 0;
      n_viol   = 0;
      n_wide   = 0;
      fall_cyc = -100;
      done_cyc = -1;
      start_cyc = -100;
      err_cyc  = -1;
      wlog.delete();
   endtask

   function automatic logic [31:0] wlog_at(input int k);
      if (k < wlog.size()) return wlog[k];
      return 32'hxxxxxxxx;
   endfunction

   typedef struct {
      logic [7:0]  idx;
      logic [31:0] exp_wdata;
   } boot_vec_t;

   typedef struct {
      logic [31:0] ext_wdata;
      logic [7:0]  riic;
      logic [31:0] exp_wdata;
      logic [7:0]  exp_rdata;
   } ext_vec_t;

   boot_vec_t boot_tab[3];
   ext_vec_t  ext_tab[3];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1);
   end

   initial begin
      int got;
      boot_tab[0] = '{8'd0, 32'h7830_0882};
      boot_tab[1] = '{8'd1, 32'h7830_0802};
      boot_tab[2] = '{8'd2, 32'h7831_0302};
      ext_tab[0]  = '{32'h7930_0a56, 8'h56, 32'h7930_0a56, 8'h56};
      ext_tab[1]  = '{32'h7830_0a12, 8'hc3, 32'h7830_0a12, 8'hc3};
      ext_tab[2]  = '{32'h7950_3d00, 8'h0f, 32'h7950_3d00, 8'h0f};
      clear_mon();

      // Reset state
      #23;
      chk("rst_start", {31'b0, start}, 32'd0);
      chk("rst_wdata", wdata, 32'd0);
      chk("rst_cfg_done", {31'b0, cfg_done}, 32'd0);
      chk("rst_cfg_err", {31'b0, cfg_err}, 32'd0);
      chk("rst_ext_ack", {31'b0, ext_ack}, 32'd0);
      chk("rst_ext_rdata", {24'b0, ext_rdata}, 32'd0);
      tick();
      s_rst_n = 1'b1;
      repeat (5) tick();
      chk("idle_no_start", n_start, 0);

      // Boot: table walk
      clear_mon();
      power_done = 1'b1;
      for (int i = 0; i < 500 && !cfg_done; i++) tick();
      chk("boot_done", {31'b0, cfg_done}, 32'd1);
      chk("boot_nstart", n_start, 3);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("boot_wdata%0d", boot_tab[k].idx), wlog_at(k), boot_tab[k].exp_wdata);
         chk($sformatf("boot_dev%0d", k), {24'b0, wlog_at(k) >> 24}, 32'h78);
      end
      chk("boot_start_vs_busy", n_viol, 0);
      chk("boot_start_width", n_wide, 0);
      chk("boot_done_timing", done_cyc - fall_cyc, 1);
      chk("boot_no_err", {31'b0, cfg_err}, 32'd0);

      // External transfers
      for (int v = 0; v < 3; v++) begin
         clear_mon();
         ext_wdata = ext_tab[v].ext_wdata;
         riic_data = ext_tab[v].riic;
         ext_req   = 1'b1;
         got = 0;
         for (int i = 0; i < 100; i++) begin
            tick();
            if (ext_ack) begin
               got = 1;
               chk($sformatf("ext%0d_rdata", v), {24'b0, ext_rdata}, {24'b0, ext_tab[v].exp_rdata});
               ext_req = 1'b0;
               break;
            end
         end
         ext_req = 1'b0;
         chk($sformatf("ext%0d_ack_seen", v), got, 1);
         repeat (5) tick();
         chk($sformatf("ext%0d_nstart", v), n_start, 1);
         chk($sformatf("ext%0d_wdata", v), wlog_at(0), ext_tab[v].exp_wdata);
         chk($sformatf("ext%0d_nack", v), n_ack, 1);
         chk($sformatf("ext%0d_start_vs_busy", v), n_viol, 0);
      end

      // Async reset while an external transfer sits in its busy-low wait
      ext_wdata = 32'h7930_0b00;
      ext_req   = 1'b1;
      for (int i = 0; i < 50 && !busy; i++) tick();
      chk("rstmid_busy_seen", {31'b0, busy}, 32'd1);
      tick();
      chk("rstmid_pre_done", {31'b0, cfg_done}, 32'd1);
      #1;
      s_rst_n = 1'b0;
      ext_req = 1'b0;
      #1;
      chk("rstmid_start", {31'b0, start}, 32'd0);
      chk("rstmid_cfg_done", {31'b0, cfg_done}, 32'd0);
      chk("rstmid_ext_ack", {31'b0, ext_ack}, 32'd0);
      chk("rstmid_wdata", wdata, 32'd0);

      // Power loss during the second table entry, then full replay
      power_done = 1'b0;
      repeat (2) tick();
      s_rst_n = 1'b1;
      clear_mon();
      power_done = 1'b1;
      for (int i = 0; i < 500 && n_start < 2; i++) tick();
      chk("pwr_second_start", n_start, 2);
      power_done = 1'b0;
      repeat (20) tick();
      chk("pwr_no_more_start", n_start, 2);
      chk("pwr_cfg_done_low", {31'b0, cfg_done}, 32'd0);
      clear_mon();
      power_done = 1'b1;
      for (int i = 0; i < 500 && !cfg_done; i++) tick();
      chk("pwr_replay_done", {31'b0, cfg_done}, 32'd1);
      chk("pwr_replay_nstart", n_start, 3);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("pwr_replay_wdata%0d", k), wlog_at(k), boot_tab[k].exp_wdata);
      end
      chk("pwr_start_vs_busy", n_viol, 0);

      // Busy timeout: master never responds
      tick();
      s_rst_n    = 1'b0;
      power_done = 1'b0;
      busy_en    = 1'b0;
      repeat (2) tick();
      s_rst_n = 1'b1;
      clear_mon();
      power_done = 1'b1;
      for (int i = 0; i < 300 && !cfg_err; i++) tick();
      chk("to_cfg_err", {31'b0, cfg_err}, 32'd1);
      chk("to_latency", err_cyc - start_cyc, 21);
      ext_req   = 1'b1;
      ext_wdata = 32'h7930_0a56;
      repeat (30) tick();
      ext_req = 1'b0;
      chk("to_nstart", n_start, 1);
      chk("to_no_ack", n_ack, 0);
      chk("to_cfg_done_low", {31'b0, cfg_done}, 32'd0);
      chk("to_err_sticky", {31'b0, cfg_err}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
